cl_dram_wr_engine: RTL and testbench
====================================

Name: cl_dram_wr_engine

Overview:
- Performance write generator that sits directly downstream of the OCL register block.
- Consumes start_addr, write_len and write_val, and on a start pulse issues AXI4 write bursts to the DDR controller port. Every beat carries write_val replicated across 512 bits.
- Reports busy, done, error and elapsed cycle count back to the register block for host readout.

Parameters:
- MAX_BURST, 16, maximum beats per burst (1..256, power of 2).
- MAX_OUTSTANDING, 8, maximum AW bursts issued without a B response; also the depth of the internal burst-length FIFO (power of 2).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle start pulse.
- start_addr  in  32  byte address; bits [5:0] are ignored (forced to 0).
- write_len  in  32  total beats to write (1 beat = 64 B).
- write_val  in  32  data pattern.
- busy  out  1  run in progress.
- done  out  1  sticky completion flag.
- error  out  1  sticky flag: any bresp != OKAY.
- cycle_cnt  out  32  cycles spent busy.
- awaddr  out  64 / awlen  out  8 / awsize  out  3 / awburst  out  2 / awvalid  out  1 / awready  in  1  AXI4 AW channel.
- wdata  out  512 / wstrb  out  64 / wlast  out  1 / wvalid  out  1 / wready  in  1  AXI4 W channel.
- bresp  in  2 / bvalid  in  1 / bready  out  1  AXI4 B channel.

Behaviour:
- Reset (asynchronous, any time, including mid-run): busy=0, done=0, error=0, cycle_cnt=0, awvalid=0, wvalid=0, wlast=0; all counters and the FIFO are cleared. Bursts in flight are abandoned.
- Constant outputs: awsize=3'b110, awburst=2'b01 (INCR), wstrb=all ones, bready=1 at all times.
- wdata = 16 copies of write_val. The three config inputs are latched on an accepted start and are not re-sampled during a run.
- FSM state IDLE:
  - start=1 and write_len!=0: latch the inputs, clear cycle_cnt/done/error, go to RUN. busy=1 and awvalid may rise on the next cycle (1-cycle latency).
  - start=1 and write_len=0: clear done/error/cycle_cnt, then set done=1 the next cycle with no AXI traffic. Stay in IDLE.
- start is ignored while busy=1.
- FSM state RUN:
  - AW path: issue a burst when aw_remaining>0, outstanding<MAX_OUTSTANDING and the FIFO is not full.
  - Burst beats = min(aw_remaining, MAX_BURST, (4096 - addr[11:0])/64), so no burst crosses a 4 KB boundary.
  - awlen = beats-1. awaddr and awlen are held stable while awvalid=1 and awready=0.
  - On the AW handshake: push beats into the FIFO, addr += beats*64 (64-bit add, no wrap), aw_remaining -= beats, outstanding++.
- W path:
  - wvalid=1 whenever the FIFO is non-empty. W never leads its AW.
  - A beat counter runs against the FIFO head; wlast=1 on the head's final beat. The head is popped on the wlast handshake.
  - A new burst may follow with zero bubble.
- B path:
  - Each bvalid decrements outstanding. If AW and B handshake in the same cycle, outstanding is unchanged.
  - bresp != 2'b00 sets error, which stays set until the next accepted start.
- Go to DONE when aw_remaining=0, the FIFO is empty, and outstanding reaches 0 on the last B.
- FSM state DONE: one transit cycle. busy=0 and done=1 appear the cycle after the final B handshake, then return to IDLE.
- cycle_cnt increments every cycle busy=1 (saturates at 2^32-1) and holds after done.
- AW-handshake count must equal B-handshake count for every completed run.

Test Plan:
- start_addr=0x1000, write_len=4, write_val=0xA5A5_0001 -> one AW (awaddr=0x1000, awlen=3); 4 beats of wdata=16×0xA5A5_0001 with wlast on beat 4; done=1 one cycle after B; cycle_cnt>0.
- start_addr=0, write_len=40, MAX_BURST=16 -> AWs at 0x000/awlen 15, 0x400/awlen 15, 0x800/awlen 7; 40 W beats; exactly 3 wlast.
- start_addr=0xFC7, write_len=3 -> AW 0xFC0/awlen 0, then AW 0x1000/awlen 1; no 4 KB crossing.
- write_len=0 -> done=1 the cycle after start; awvalid never asserted; busy stays 0.
- write_len=200, bvalid withheld -> exactly 8 AWs accepted, then awvalid=0. Hold awready low 10 cycles mid-run -> awaddr/awlen stable. Random wready -> beat count still correct.
- bresp=2'b10 on burst 2 of 3 -> error=1, run completes with done=1. Second start while busy -> ignored. rst_n low mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/cl_dram_wr_engine.sv
// Performance write generator: streams write_len beats of a replicated 32-bit
// pattern to DDR as 4 KB-safe AXI4 INCR bursts, reporting status and elapsed cycles.
module cl_dram_wr_engine #(
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [31:0]  start_addr,
  input  logic [31:0]  write_len,
  input  logic [31:0]  write_val,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [31:0]  cycle_cnt,
  output logic [63:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [511:0] wdata,
  output logic [63:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW    = PW + 1;
  localparam int DEPTH = 2 ** PW;
  localparam logic [8:0]    MAX_BURST_9 = 9'(MAX_BURST);
  localparam logic [31:0]   MAX_BURST_W = 32'(MAX_BURST);
  localparam logic [CW-1:0] MAX_OUT_W   = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, next_state;
  logic [31:0]   val_q;
  logic [63:0]   addr_q;
  logic [31:0]   aw_remaining;
  logic [CW-1:0] outstanding;
  logic [8:0]    fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [8:0]    beat_cnt;
  logic [8:0]    head_beats;
  logic [6:0]    bnd_beats;
  logic [8:0]    rem_clip;
  logic [8:0]    beats;
  logic          aw_hs, w_hs, w_pop, b_hs;
  logic          fifo_full, can_issue, start_run, start_zero;

  assign awsize  = 3'b110;
  assign awburst = 2'b01;
  assign wstrb   = '1;
  assign bready  = 1'b1;
  assign wdata   = {16{val_q}};

  assign head_beats = fifo_mem[rd_ptr];
  assign wvalid     = (fifo_cnt != '0);
  assign wlast      = wvalid && (beat_cnt == head_beats - 9'd1);
  assign fifo_full  = (fifo_cnt == MAX_OUT_W);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign w_pop = w_hs && wlast;
  assign b_hs  = bvalid && (state == RUN);

  // Burst size is the smallest of what is left, the burst cap and the room before the next 4 KB page.
  always_comb begin
    bnd_beats = 7'd64 - {1'b0, addr_q[11:6]};
    rem_clip  = (aw_remaining > MAX_BURST_W) ? MAX_BURST_9 : aw_remaining[8:0];
    beats     = (rem_clip > {2'b00, bnd_beats}) ? {2'b00, bnd_beats} : rem_clip;
  end

  assign can_issue = (state == RUN) && !awvalid && (aw_remaining != '0) &&
                     (outstanding < MAX_OUT_W) && !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    start_run  = 1'b0;
    start_zero = 1'b0;
    case (state)
      IDLE: begin
        if (start && (write_len != '0)) begin
          start_run  = 1'b1;
          next_state = RUN;
        end else if (start) begin
          start_zero = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if ((aw_remaining == '0) && !awvalid && (fifo_cnt == '0) &&
            ((outstanding == '0) || ((outstanding == CW'(1)) && b_hs)))
          next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aw_hs) fifo_mem[wr_ptr] <= beats;
  end

  // Datapath: the AW request is captured once and held until accepted, so its fields stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q        <= '0;
      addr_q       <= '0;
      aw_remaining <= '0;
      outstanding  <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      beat_cnt     <= '0;
      awvalid      <= 1'b0;
      awaddr       <= '0;
      awlen        <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      cycle_cnt    <= '0;
    end else if (start_run) begin
      val_q        <= write_val;
      addr_q       <= {32'd0, start_addr & 32'hFFFF_FFC0};
      aw_remaining <= write_len;
      outstanding  <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      cycle_cnt    <= '0;
    end else if (start_zero) begin
      done      <= 1'b1;
      error     <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      if ((state == RUN) && (cycle_cnt != 32'hFFFF_FFFF))
        cycle_cnt <= cycle_cnt + 32'd1;
      if ((state == RUN) && (next_state == DONE))
        done <= 1'b1;
      if (b_hs && (bresp != 2'b00))
        error <= 1'b1;

      if (aw_hs) begin
        awvalid      <= 1'b0;
        addr_q       <= addr_q + {49'd0, beats, 6'd0};
        aw_remaining <= aw_remaining - {23'd0, beats};
        wr_ptr       <= wr_ptr + PW'(1);
      end else if (can_issue) begin
        awvalid <= 1'b1;
        awaddr  <= addr_q;
        awlen   <= 8'(beats - 9'd1);
      end

      if (w_hs) begin
        if (wlast) begin
          beat_cnt <= '0;
          rd_ptr   <= rd_ptr + PW'(1);
        end else begin
          beat_cnt <= beat_cnt + 9'd1;
        end
      end

      case ({aw_hs, w_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      case ({aw_hs, b_hs && (outstanding != '0)})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_cl_dram_wr_engine.sv
// Directed bench for cl_dram_wr_engine with a simple AXI4 write slave and handshake monitors.
module tb_cl_dram_wr_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  start_addr = '0;
  logic [31:0]  write_len = '0;
  logic [31:0]  write_val = '0;
  logic         busy, done, error;
  logic [31:0]  cycle_cnt;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast, wvalid;
  logic         wready = 1'b0;
  logic [1:0]   bresp = 2'b00;
  logic         bvalid = 1'b0;
  logic         bready;

  cl_dram_wr_engine #(.MAX_BURST(16), .MAX_OUTSTANDING(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .write_len(write_len), .write_val(write_val), .busy(busy), .done(done),
    .error(error), .cycle_cnt(cycle_cnt), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Slave controls, written only by the stimulus process
  logic        aw_stall = 1'b0;
  logic        b_hold = 1'b0;
  logic        w_random = 1'b0;
  int          err_burst = -1;
  logic [31:0] cur_val = '0;
  int          clr_seq = 0;

  // Slave/monitor state, written only by the slave process
  int          clr_seen = 0;
  logic [63:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  int          bq[$];
  int          aw_count, w_beats, wlast_count, b_count, beat_in_burst;
  int          data_err, wlast_err, cross_err, stab_err, awv_seen, busy_seen, out_max;
  logic        b_hs_prev, wl_hs_prev, aw_wait_prev;
  logic [63:0] aw_addr_prev;
  logic [7:0]  aw_len_prev;

  // Inputs change at the falling edge; handshakes that will complete at the next rising edge are logged here.
  always @(negedge clk) begin
    if (!rst_n || (clr_seq != clr_seen)) begin
      clr_seen = clr_seq;
      aw_addr_q.delete(); aw_len_q.delete(); bq.delete();
      aw_count = 0; w_beats = 0; wlast_count = 0; b_count = 0; beat_in_burst = 0;
      data_err = 0; wlast_err = 0; cross_err = 0; stab_err = 0;
      awv_seen = 0; busy_seen = 0; out_max = 0;
      b_hs_prev = 0; wl_hs_prev = 0; aw_wait_prev = 0;
      bvalid = 1'b0; bresp = 2'b00; awready = 1'b0; wready = 1'b0;
    end else begin
      if (b_hs_prev) void'(bq.pop_front());
      if (wl_hs_prev) bq.push_back(wlast_count - 1);
      awready = !aw_stall;
      wready  = w_random ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid  = !b_hold && (bq.size() > 0);
      bresp   = (bvalid && (bq[0] == err_burst)) ? 2'b10 : 2'b00;
      if (awvalid) awv_seen++;
      if (busy) busy_seen++;
      if (aw_wait_prev && ((awaddr !== aw_addr_prev) || (awlen !== aw_len_prev))) stab_err++;
      aw_wait_prev = awvalid && !awready;
      aw_addr_prev = awaddr;
      aw_len_prev  = awlen;
      if (awvalid && awready) begin
        aw_addr_q.push_back(awaddr);
        aw_len_q.push_back(awlen);
        if ({52'd0, awaddr[11:0]} + (64'(awlen) + 64'd1) * 64'd64 > 64'd4096) cross_err++;
        aw_count++;
      end
      wl_hs_prev = 1'b0;
      if (wvalid && wready) begin
        w_beats++;
        if (wdata !== {16{cur_val}}) data_err++;
        if (wlast_count >= aw_len_q.size()) wlast_err++;
        else if (wlast !== (beat_in_burst == int'(aw_len_q[wlast_count]))) wlast_err++;
        if (wlast) begin
          wlast_count++;
          beat_in_burst = 0;
          wl_hs_prev = 1'b1;
        end else begin
          beat_in_burst++;
        end
      end
      b_hs_prev = bvalid;
      if (bvalid) b_count++;
      if (aw_count - b_count > out_max) out_max = aw_count - b_count;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clearLogs();
    clr_seq++;
    tick(1);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] len, input logic [31:0] val);
    @(negedge clk);
    #1;
    start_addr = addr;
    write_len  = len;
    write_val  = val;
    start      = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      tick(1);
    end
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    logic [31:0] cyc_snap;
    $display("[TB] reset state");
    tick(3);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_error", 64'(error), 64'd0);
    checkOutput("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    checkOutput("rst_awvalid", 64'(awvalid), 64'd0);
    checkOutput("rst_wvalid", 64'(wvalid), 64'd0);
    checkOutput("rst_wlast", 64'(wlast), 64'd0);
    checkOutput("const_awsize", 64'(awsize), 64'd6);
    checkOutput("const_awburst", 64'(awburst), 64'd1);
    checkOutput("const_wstrb", wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("const_bready", 64'(bready), 64'd1);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] single burst at 0x1000");
    clearLogs();
    cur_val = 32'hA5A5_0001;
    applyStimulus(32'h1000, 32'd4, cur_val);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    checkOutput("t1_done_clr", 64'(done), 64'd0);
    for (int i = 0; i < 200; i++) begin
      if (bvalid) break;
      tick(1);
    end
    checkOutput("t1_bvalid_seen", 64'(bvalid), 64'd1);
    checkOutput("t1_busy_at_b", 64'(busy), 64'd1);
    checkOutput("t1_done_at_b", 64'(done), 64'd0);
    tick(1);
    checkOutput("t1_done_after_b", 64'(done), 64'd1);
    checkOutput("t1_busy_after_b", 64'(busy), 64'd0);
    checkOutput("t1_aw_count", 64'(aw_count), 64'd1);
    checkOutput("t1_awaddr", aw_addr_q[0], 64'h1000);
    checkOutput("t1_awlen", 64'(aw_len_q[0]), 64'd3);
    checkOutput("t1_w_beats", 64'(w_beats), 64'd4);
    checkOutput("t1_wlast_count", 64'(wlast_count), 64'd1);
    checkOutput("t1_wlast_pos", 64'(wlast_err), 64'd0);
    checkOutput("t1_wdata", 64'(data_err), 64'd0);
    checkOutput("t1_cycle_pos", 64'(cycle_cnt != 32'd0), 64'd1);
    cyc_snap = cycle_cnt;
    tick(3);
    checkOutput("t1_cycle_hold", 64'(cycle_cnt), 64'(cyc_snap));

    $display("[TB] 40 beats from address 0");
    clearLogs();
    cur_val = 32'h1234_5678;
    applyStimulus(32'h0, 32'd40, cur_val);
    waitDone("t2", 500);
    checkOutput("t2_aw_count", 64'(aw_count), 64'd3);
    checkOutput("t2_awaddr0", aw_addr_q[0], 64'h000);
    checkOutput("t2_awlen0", 64'(aw_len_q[0]), 64'd15);
    checkOutput("t2_awaddr1", aw_addr_q[1], 64'h400);
    checkOutput("t2_awlen1", 64'(aw_len_q[1]), 64'd15);
    checkOutput("t2_awaddr2", aw_addr_q[2], 64'h800);
    checkOutput("t2_awlen2", 64'(aw_len_q[2]), 64'd7);
    checkOutput("t2_w_beats", 64'(w_beats), 64'd40);
    checkOutput("t2_wlast_count", 64'(wlast_count), 64'd3);
    checkOutput("t2_wlast_pos", 64'(wlast_err), 64'd0);
    checkOutput("t2_wdata", 64'(data_err), 64'd0);
    checkOutput("t2_b_count", 64'(b_count), 64'd3);

    $display("[TB] 4 KB boundary split");
    clearLogs();
    cur_val = 32'hDEAD_BEEF;
    applyStimulus(32'hFC7, 32'd3, cur_val);
    waitDone("t3", 300);
    checkOutput("t3_aw_count", 64'(aw_count), 64'd2);
    checkOutput("t3_awaddr0", aw_addr_q[0], 64'hFC0);
    checkOutput("t3_awlen0", 64'(aw_len_q[0]), 64'd0);
    checkOutput("t3_awaddr1", aw_addr_q[1], 64'h1000);
    checkOutput("t3_awlen1", 64'(aw_len_q[1]), 64'd1);
    checkOutput("t3_cross", 64'(cross_err), 64'd0);
    checkOutput("t3_w_beats", 64'(w_beats), 64'd3);

    $display("[TB] zero length");
    clearLogs();
    applyStimulus(32'h3000, 32'd0, 32'h0);
    checkOutput("t4_done", 64'(done), 64'd1);
    checkOutput("t4_busy", 64'(busy), 64'd0);
    checkOutput("t4_cycle_clr", 64'(cycle_cnt), 64'd0);
    tick(6);
    checkOutput("t4_awvalid_seen", 64'(awv_seen), 64'd0);
    checkOutput("t4_busy_seen", 64'(busy_seen), 64'd0);
    checkOutput("t4_done_hold", 64'(done), 64'd1);

    $display("[TB] outstanding limit, AW stall, random wready");
    clearLogs();
    cur_val = 32'h0F0F_3C3C;
    b_hold   = 1'b1;
    aw_stall = 1'b1;
    w_random = 1'b1;
    applyStimulus(32'h2000, 32'd200, cur_val);
    tick(10);
    checkOutput("t5_awvalid_stalled", 64'(awvalid), 64'd1);
    checkOutput("t5_awaddr_stalled", awaddr, 64'h2000);
    checkOutput("t5_awlen_stalled", 64'(awlen), 64'd15);
    aw_stall = 1'b0;
    tick(1000);
    checkOutput("t5_aw_capped", 64'(aw_count), 64'd8);
    checkOutput("t5_awvalid_low", 64'(awvalid), 64'd0);
    checkOutput("t5_w_beats_partial", 64'(w_beats), 64'd128);
    checkOutput("t5_busy_held", 64'(busy), 64'd1);
    b_hold = 1'b0;
    waitDone("t5", 2000);
    checkOutput("t5_aw_count", 64'(aw_count), 64'd13);
    checkOutput("t5_b_count", 64'(b_count), 64'd13);
    checkOutput("t5_w_beats", 64'(w_beats), 64'd200);
    checkOutput("t5_wlast_count", 64'(wlast_count), 64'd13);
    checkOutput("t5_wlast_pos", 64'(wlast_err), 64'd0);
    checkOutput("t5_wdata", 64'(data_err), 64'd0);
    checkOutput("t5_stable", 64'(stab_err), 64'd0);
    checkOutput("t5_out_max", 64'(out_max), 64'd8);
    checkOutput("t5_last_addr", aw_addr_q[12], 64'h5000);
    checkOutput("t5_last_len", 64'(aw_len_q[12]), 64'd7);
    checkOutput("t5_error", 64'(error), 64'd0);
    w_random = 1'b0;

    $display("[TB] error response and ignored restart");
    clearLogs();
    cur_val = 32'h5555_AAAA;
    err_burst = 1;
    applyStimulus(32'h0, 32'd40, cur_val);
    tick(2);
    applyStimulus(32'h8000, 32'd1, 32'h0000_0BAD);
    waitDone("t6", 500);
    checkOutput("t6_error", 64'(error), 64'd1);
    checkOutput("t6_aw_count", 64'(aw_count), 64'd3);
    checkOutput("t6_awaddr2", aw_addr_q[2], 64'h800);
    checkOutput("t6_wdata", 64'(data_err), 64'd0);
    tick(4);
    checkOutput("t6_no_restart", 64'(busy_seen), 64'(cycle_cnt));
    err_burst = -1;

    $display("[TB] error cleared by next start");
    clearLogs();
    cur_val = 32'h0000_0077;
    applyStimulus(32'h40, 32'd1, cur_val);
    checkOutput("t7_error_clr", 64'(error), 64'd0);
    waitDone("t7", 200);
    checkOutput("t7_awaddr", aw_addr_q[0], 64'h40);
    checkOutput("t7_awlen", 64'(aw_len_q[0]), 64'd0);

    $display("[TB] reset mid-burst");
    clearLogs();
    cur_val = 32'hCAFE_F00D;
    applyStimulus(32'h0, 32'd40, cur_val);
    for (int i = 0; i < 100; i++) begin
      if (wvalid) break;
      tick(1);
    end
    checkOutput("t8_wvalid_seen", 64'(wvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t8_busy", 64'(busy), 64'd0);
    checkOutput("t8_done", 64'(done), 64'd0);
    checkOutput("t8_error", 64'(error), 64'd0);
    checkOutput("t8_cycle_cnt", 64'(cycle_cnt), 64'd0);
    checkOutput("t8_awvalid", 64'(awvalid), 64'd0);
    checkOutput("t8_wvalid", 64'(wvalid), 64'd0);
    checkOutput("t8_wlast", 64'(wlast), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clearLogs();
    cur_val = 32'h1111_2222;
    applyStimulus(32'h100, 32'd2, cur_val);
    waitDone("t8_recover", 200);
    checkOutput("t8_recover_beats", 64'(w_beats), 64'd2);
    checkOutput("t8_recover_addr", aw_addr_q[0], 64'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
